// File: rtl/multicycle_control.sv
// Moore control FSM for an RV32I multicycle datapath (lw, sw, addi, add/sub/and/or, beq).
// Strobes are registered from the next state; PCWrite folds in the live ALU zero flag for beq.
module multicycle_control #(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             regWrite,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic [3:0]       state,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_EXEC_I    = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    // pc_write_cond marks the beq cycle; it is qualified with zero at the output.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [2:0] f3, input logic f7);
        ctrl_t c;
        c             = ctrl_t'(16'h0000);
        c.alu_control = 4'b0010;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE:    c.alu_src_b = 2'b10;
            S_MEM_ADDR, S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                case (f3)
                    3'b000:  c.alu_control = f7 ? 4'b0110 : 4'b0010;
                    3'b111:  c.alu_control = 4'b0000;
                    3'b110:  c.alu_control = 4'b0001;
                    default: c.alu_control = 4'b0010;
                endcase
            end
            S_ALU_WB:    c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_control   = 4'b0110;
                c.pc_source     = 1'b1;
                c.pc_write_cond = 1'b1;
            end
            default:     c.alu_control = 4'b0010;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE: ok = 1'b1;
            OP_RTYPE:          ok = (f3 == 3'b000) ||
                                    (!f7 && ((f3 == 3'b110) || (f3 == 3'b111)));
            OP_ITYPE:          ok = (f3 == 3'b000);
            OP_BRANCH:         ok = (f3 == 3'b000);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             legal_s;
    logic             retire_s;

    // Next-state sequencing and opcode dispatch
    always_comb begin
        legal_s = is_legal(opcode, funct3, funct7_5);
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (!legal_s) begin
                    state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                        OP_RTYPE:          state_d = S_EXEC_R;
                        OP_ITYPE:          state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // Retirement count and control word for the upcoming state
    always_comb begin
        retire_s = (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                   (state_q == S_ALU_WB) || (state_q == S_BRANCH);
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
        ctrl_d = decode_ctrl(state_d, funct3, funct7_5);
    end

    // State, control word and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH, 3'b000, 1'b0);
            retired_q <= CNT_W'(0);
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
        end
    end

    // Reset masks every strobe and returns selects to their defaults
    always_comb begin
        if (reset) begin
            PCWrite       = 1'b0;
            IorD          = 1'b0;
            memRead       = 1'b0;
            memWrite      = 1'b0;
            IRWrite       = 1'b0;
            MemtoReg      = 1'b0;
            regWrite      = 1'b0;
            PCSource      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            ALUControl    = 4'b0010;
            illegal_instr = 1'b0;
        end else begin
            PCWrite       = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);
            IorD          = ctrl_q.iord;
            memRead       = ctrl_q.mem_read;
            memWrite      = ctrl_q.mem_write;
            IRWrite       = ctrl_q.ir_write;
            MemtoReg      = ctrl_q.mem_to_reg;
            regWrite      = ctrl_q.reg_write;
            PCSource      = ctrl_q.pc_source;
            ALUSrcA       = ctrl_q.alu_src_a;
            ALUSrcB       = ctrl_q.alu_src_b;
            ALUControl    = ctrl_q.alu_control;
            illegal_instr = (state_q == S_DECODE) && !legal_s;
        end
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a behavioural datapath runs small programs while an ISA-level
// reference queues the expected state/control word of every cycle and the final architectural state.
module tb_multicycle_control;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dp_clr = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic        PCWrite0, IorD0, memRead0, memWrite0, IRWrite0, MemtoReg0, regWrite0, PCSource0, ALUSrcA0, illegal0;
    logic [1:0]  ALUSrcB0;
    logic [3:0]  ALUControl0, state0;
    logic [31:0] retired0;
    logic        PCWrite1, IorD1, memRead1, memWrite1, IRWrite1, MemtoReg1, regWrite1, PCSource1, ALUSrcA1, illegal1;
    logic [1:0]  ALUSrcB1;
    logic [3:0]  ALUControl1, state1;
    logic [31:0] retired1;
    logic        zero_s;

    instr_t      prog [16];
    int          plen;
    logic [31:0] pc_m, a_m, b_m, aluout_m, mdr_m, src_a, src_b, alu_res;
    instr_t      ir_m;
    logic [31:0] regs_m [32];
    logic [31:0] dmem_m [16];

    multicycle_control #(.CNT_W(32), .ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(ir_m.op), .funct3(ir_m.f3), .funct7_5(ir_m.f7), .zero(zero_s),
        .PCWrite(PCWrite0), .IorD(IorD0), .memRead(memRead0), .memWrite(memWrite0), .IRWrite(IRWrite0),
        .MemtoReg(MemtoReg0), .regWrite(regWrite0), .PCSource(PCSource0), .ALUSrcA(ALUSrcA0),
        .ALUSrcB(ALUSrcB0), .ALUControl(ALUControl0), .state(state0), .illegal_instr(illegal0),
        .instr_retired(retired0));

    multicycle_control #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(ir_m.op), .funct3(ir_m.f3), .funct7_5(ir_m.f7), .zero(zero_s),
        .PCWrite(PCWrite1), .IorD(IorD1), .memRead(memRead1), .memWrite(memWrite1), .IRWrite(IRWrite1),
        .MemtoReg(MemtoReg1), .regWrite(regWrite1), .PCSource(PCSource1), .ALUSrcA(ALUSrcA1),
        .ALUSrcB(ALUSrcB1), .ALUControl(ALUControl1), .state(state1), .illegal_instr(illegal1),
        .instr_retired(retired1));

    logic [15:0] obs0, obs1;
    assign obs0 = {PCWrite0, IorD0, memRead0, memWrite0, IRWrite0, MemtoReg0, regWrite0, PCSource0,
                   ALUSrcA0, ALUSrcB0, ALUControl0, illegal0};
    assign obs1 = {PCWrite1, IorD1, memRead1, memWrite1, IRWrite1, MemtoReg1, regWrite1, PCSource1,
                   ALUSrcA1, ALUSrcB1, ALUControl1, illegal1};

    // Datapath ALU, steered by dut0
    always_comb begin
        src_a = ALUSrcA0 ? a_m : pc_m;
        case (ALUSrcB0)
            2'b00:   src_b = b_m;
            2'b01:   src_b = 32'd4;
            default: src_b = ir_m.imm;
        endcase
        case (ALUControl0)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0110: alu_res = src_a - src_b;
            default: alu_res = src_a + src_b;
        endcase
    end
    assign zero_s = (alu_res == 32'd0);

    // Datapath registers, regfile and memories
    always @(posedge clk) begin
        if (reset) begin
            pc_m <= 32'd0;
            if (dp_clr) begin
                ir_m <= '0;
                for (int i = 0; i < 32; i++) regs_m[i] <= 32'd0;
                for (int i = 0; i < 16; i++) dmem_m[i] <= 32'h100 + 32'(i);
            end
        end else begin
            a_m      <= regs_m[ir_m.rs1];
            b_m      <= regs_m[ir_m.rs2];
            aluout_m <= alu_res;
            if (IRWrite0) ir_m <= prog[pc_m[5:2]];
            if (memRead0 && IorD0) mdr_m <= dmem_m[aluout_m[5:2]];
            if (memWrite0) dmem_m[aluout_m[5:2]] <= b_m;
            if (regWrite0 && ir_m.rd != 5'd0) regs_m[ir_m.rd] <= MemtoReg0 ? mdr_m : aluout_m;
            if (PCWrite0) pc_m <= PCSource0 ? aluout_m : alu_res;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected {PCWrite,IorD,memRead,memWrite,IRWrite,MemtoReg,regWrite,PCSource,ALUSrcA,ALUSrcB,ALUControl,illegal}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [2:0] f3, input logic f7,
                                            input logic taken, input logic ill);
        logic pcw, iord, mr, mw, irw, m2r, rw, pcs, asa;
        logic [1:0] asb;
        logic [3:0] alu;
        {pcw, iord, mr, mw, irw, m2r, rw, pcs, asa} = 9'd0;
        asb = 2'b00;
        alu = 4'b0010;
        case (st)
            4'd0: begin mr = 1'b1; irw = 1'b1; asb = 2'b01; pcw = 1'b1; end
            4'd1: asb = 2'b10;
            4'd2: begin asa = 1'b1; asb = 2'b10; end
            4'd3: begin mr = 1'b1; iord = 1'b1; end
            4'd4: begin rw = 1'b1; m2r = 1'b1; end
            4'd5: begin mw = 1'b1; iord = 1'b1; end
            4'd6: begin
                asa = 1'b1;
                if (f3 == 3'b111) alu = 4'b0000;
                else if (f3 == 3'b110) alu = 4'b0001;
                else if (f7) alu = 4'b0110;
                else alu = 4'b0010;
            end
            4'd7: rw = 1'b1;
            4'd8: begin asa = 1'b1; alu = 4'b0110; pcs = 1'b1; pcw = taken; end
            4'd9: begin asa = 1'b1; asb = 2'b10; end
            default: ;
        endcase
        return {pcw, iord, mr, mw, irw, m2r, rw, pcs, asa, asb, alu, (st == 4'd1) && ill};
    endfunction

    function automatic bit legal_ref(input instr_t i);
        case (i.op)
            OP_LW, OP_SW: return 1'b1;
            OP_R:         return (i.f3 == 3'b000) || (!i.f7 && (i.f3 == 3'b110 || i.f3 == 3'b111));
            OP_I, OP_B:   return i.f3 == 3'b000;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input int rd, input int rs1, input int rs2, input int imm);
        return '{op: op, f3: f3, f7: f7, rd: 5'(rd), rs1: 5'(rs1), rs2: 5'(rs2), imm: 32'(imm)};
    endfunction

    exp_t        exp_q [$];
    logic [31:0] e_regs [32];
    logic [31:0] e_mem [16];
    logic [31:0] e_pc;
    int          e_ret;

    task automatic push_st(input logic [3:0] st, input instr_t i, input logic tk, input logic ill);
        exp_q.push_back({st, exp_ctrl(st, i.f3, i.f7, tk, ill)});
    endtask

    // Instruction-level reference: queues per-cycle expectations and final architectural state
    task automatic interp(input int max_instr);
        logic [31:0] pc, pcn, addr, x, y, r;
        instr_t ins;
        logic tk;
        int n;
        for (int i = 0; i < 32; i++) e_regs[i] = 32'd0;
        for (int i = 0; i < 16; i++) e_mem[i] = 32'h100 + 32'(i);
        e_ret = 0;
        pc = 32'd0;
        n = 0;
        while (pc < 32'(4 * plen) && n < max_instr) begin
            ins = prog[pc[5:2]];
            n++;
            pcn = pc + 32'd4;
            x = e_regs[ins.rs1];
            y = e_regs[ins.rs2];
            r = 32'd0;
            addr = x + ins.imm;
            push_st(4'd0, ins, 1'b0, 1'b0);
            push_st(4'd1, ins, 1'b0, !legal_ref(ins));
            pc = pcn;
            if (legal_ref(ins)) begin
                e_ret++;
                case (ins.op)
                    OP_LW: begin
                        push_st(4'd2, ins, 1'b0, 1'b0); push_st(4'd3, ins, 1'b0, 1'b0);
                        push_st(4'd4, ins, 1'b0, 1'b0);
                        r = e_mem[addr[5:2]];
                    end
                    OP_SW: begin
                        push_st(4'd2, ins, 1'b0, 1'b0); push_st(4'd5, ins, 1'b0, 1'b0);
                        e_mem[addr[5:2]] = y;
                    end
                    OP_R: begin
                        push_st(4'd6, ins, 1'b0, 1'b0); push_st(4'd7, ins, 1'b0, 1'b0);
                        if (ins.f3 == 3'b111) r = x & y;
                        else if (ins.f3 == 3'b110) r = x | y;
                        else r = ins.f7 ? x - y : x + y;
                    end
                    OP_I: begin
                        push_st(4'd9, ins, 1'b0, 1'b0); push_st(4'd7, ins, 1'b0, 1'b0);
                        r = addr;
                    end
                    default: begin
                        tk = (x == y);
                        push_st(4'd8, ins, tk, 1'b0);
                        if (tk) pc = pcn + ins.imm;
                    end
                endcase
                if (ins.op != OP_SW && ins.op != OP_B && ins.rd != 5'd0) e_regs[ins.rd] = r;
            end
        end
        e_pc = pc;
    endtask

    task automatic load(input instr_t p [16], input int n);
        for (int i = 0; i < 16; i++) prog[i] = p[i];
        plen = n;
    endtask

    task automatic do_reset(input logic clr);
        @(negedge clk);
        reset = 1'b1;
        dp_clr = clr;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state0), 32'd0);
        check_eq("rst_ctrl", 32'(obs0), 32'(exp_ctrl(4'd10, 3'b000, 1'b0, 1'b0, 1'b0)));
        check_eq("rst_retired", retired0, 32'd0);
        check_eq("rst_trap_state", 32'(state1), 32'd0);
        reset = 1'b0;
        dp_clr = 1'b0;
    endtask

    task automatic run_queue(input bit chk_trap);
        exp_t e;
        bit halted;
        halted = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            check_eq("state", 32'(state0), 32'(e.st));
            check_eq("ctrl", 32'(obs0), 32'(e.ctrl));
            if (chk_trap && halted) begin
                check_eq("trap_state", 32'(state1), 32'd10);
                check_eq("trap_ctrl", 32'(obs1), 32'(exp_ctrl(4'd10, 3'b000, 1'b0, 1'b0, 1'b0)));
            end else if (chk_trap) begin
                check_eq("trap_state", 32'(state1), 32'(e.st));
                check_eq("trap_ctrl", 32'(obs1), 32'(e.ctrl));
                if (e.st == 4'd1 && e.ctrl[0]) halted = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_final();
        #1;
        check_eq("final_pc", pc_m, e_pc);
        check_eq("final_retired", retired0, 32'(e_ret));
        for (int i = 1; i < 32; i++) check_eq($sformatf("x%0d", i), regs_m[i], e_regs[i]);
        for (int i = 0; i < 16; i++) check_eq($sformatf("mem%0d", i), dmem_m[i], e_mem[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        instr_t p [16];
        for (int i = 0; i < 16; i++) p[i] = '0;

        // Countdown loop: exits to PC=16 with x5=0
        p[0] = mk(OP_I, 3'b000, 1'b0, 5, 0, 0, 4);
        p[1] = mk(OP_I, 3'b000, 1'b0, 5, 5, 0, -1);
        p[2] = mk(OP_B, 3'b000, 1'b0, 0, 5, 0, 4);
        p[3] = mk(OP_B, 3'b000, 1'b0, 0, 0, 0, -12);
        load(p, 4);
        do_reset(1'b1);
        interp(100);
        run_queue(1'b1);
        check_final();
        check_eq("loop_pc", pc_m, 32'd16);
        check_eq("loop_x5", regs_m[5], 32'd0);

        // ALU ops, lw/sw, branch not taken and taken
        p[0]  = mk(OP_I, 3'b000, 1'b0, 1, 0, 0, 7);
        p[1]  = mk(OP_I, 3'b000, 1'b0, 2, 0, 0, 3);
        p[2]  = mk(OP_R, 3'b000, 1'b1, 3, 1, 2, 0);
        p[3]  = mk(OP_R, 3'b000, 1'b0, 4, 1, 2, 0);
        p[4]  = mk(OP_R, 3'b111, 1'b0, 6, 1, 2, 0);
        p[5]  = mk(OP_R, 3'b110, 1'b0, 7, 1, 2, 0);
        p[6]  = mk(OP_LW, 3'b010, 1'b0, 8, 0, 0, 8);
        p[7]  = mk(OP_SW, 3'b010, 1'b0, 0, 0, 3, 12);
        p[8]  = mk(OP_LW, 3'b010, 1'b0, 9, 0, 0, 12);
        p[9]  = mk(OP_B, 3'b000, 1'b0, 0, 1, 2, 8);
        p[10] = mk(OP_B, 3'b000, 1'b0, 0, 9, 3, 4);
        p[11] = mk(OP_I, 3'b000, 1'b0, 10, 0, 0, 99);
        p[12] = mk(OP_I, 3'b000, 1'b0, 11, 0, 0, 1);
        load(p, 13);
        do_reset(1'b1);
        interp(100);
        run_queue(1'b1);
        check_final();

        // Unsupported encodings: skipped by dut0, dut1 traps into HALT
        for (int i = 0; i < 16; i++) p[i] = '0;
        p[0] = mk(OP_I, 3'b000, 1'b0, 1, 0, 0, 1);
        p[1] = mk(7'b1111111, 3'b000, 1'b0, 2, 0, 0, 0);
        p[2] = mk(OP_R, 3'b001, 1'b0, 3, 1, 1, 0);
        p[3] = mk(OP_R, 3'b111, 1'b1, 4, 1, 1, 0);
        p[4] = mk(OP_I, 3'b010, 1'b0, 5, 0, 0, 9);
        p[5] = mk(OP_I, 3'b000, 1'b0, 2, 0, 0, 2);
        load(p, 6);
        do_reset(1'b1);
        interp(100);
        run_queue(1'b1);
        check_final();
        for (int c = 0; c < 20; c++) begin
            check_eq("halt_hold", 32'(state1), 32'd10);
            check_eq("halt_ctrl", 32'(obs1), 32'(exp_ctrl(4'd10, 3'b000, 1'b0, 1'b0, 1'b0)));
            @(negedge clk);
        end
        check_eq("halt_retired", retired1, 32'd1);

        // Reset during MEM_READ of a lw aborts it without a register write
        p[0] = mk(OP_I, 3'b000, 1'b0, 8, 0, 0, 5);
        p[1] = mk(OP_LW, 3'b010, 1'b0, 8, 0, 0, 4);
        load(p, 2);
        do_reset(1'b1);
        interp(1);
        push_st(4'd0, p[1], 1'b0, 1'b0);
        push_st(4'd1, p[1], 1'b0, 1'b0);
        push_st(4'd2, p[1], 1'b0, 1'b0);
        run_queue(1'b0);
        #1;
        check_eq("abort_in_memread", 32'(state0), 32'd3);
        check_eq("abort_memread_ctrl", 32'(obs0), 32'(exp_ctrl(4'd3, 3'b010, 1'b0, 1'b0, 1'b0)));
        reset = 1'b1;
        #1;
        check_eq("abort_rst_ctrl", 32'(obs0), 32'(exp_ctrl(4'd10, 3'b000, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        check_eq("abort_state", 32'(state0), 32'd0);
        check_eq("abort_regwrite", 32'(regWrite0), 32'd0);
        check_eq("abort_retired", retired0, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("abort_fetch_ctrl", 32'(obs0), 32'(exp_ctrl(4'd0, 3'b000, 1'b0, 1'b0, 1'b0)));
        check_eq("abort_trap_state", 32'(state1), 32'd0);
        check_eq("abort_x8", regs_m[8], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
